// File: rtl/dp_result_reducer.sv
// rtl/dp_result_reducer.sv - N-channel dot-product result combiner (bypass, pair, full, accumulate)
module dp_result_reducer #(
   parameter int N_CH       = 4,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   input  logic                       start_i,
   input  logic [1:0]                 mode_i,
   input  logic [LEN_WIDTH-1:0]       len_i,
   input  logic [N_CH*DATA_WIDTH-1:0] in_data_i,
   input  logic [N_CH-1:0]            in_valid_i,
   output logic [N_CH-1:0]            in_ready_o,
   output logic [N_CH*DATA_WIDTH-1:0] out_data_o,
   output logic [N_CH-1:0]            out_valid_o,
   input  logic [N_CH-1:0]            out_ready_i,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam logic [1:0] MODE_BYPASS = 2'd0;
   localparam logic [1:0] MODE_PAIR   = 2'd1;
   localparam logic [1:0] MODE_ACCUM  = 2'd3;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_EMIT = 2'd2, ST_DRAIN = 2'd3} state_t;

   state_t                state_q;
   logic [1:0]            mode_q;
   logic [LEN_WIDTH-1:0]  cnt_q;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [DATA_WIDTH-1:0] out_data_q [N_CH];
   logic [N_CH-1:0]       out_valid_q;

   logic [DATA_WIDTH-1:0] full_sum;
   logic [DATA_WIDTH-1:0] comb_data [N_CH];
   logic [N_CH-1:0]       active;
   logic [N_CH-1:0]       slot_free;
   logic [N_CH-1:0]       slot_hs;
   logic                  accept;
   logic                  last_beat;
   logic                  done;

   // Sum of every input channel, shared by FULL and ACCUM
   always_comb begin
      full_sum = '0;
      for (int k = 0; k < N_CH; k++) begin
         full_sum = full_sum + in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Per-channel combined data for the latched mode; unused channels stay zero
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         comb_data[k] = '0;
      end
      case (mode_q)
         MODE_BYPASS: begin
            for (int k = 0; k < N_CH; k++) begin
               comb_data[k] = in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         MODE_PAIR: begin
            for (int p = 0; p < N_CH/2; p++) begin
               comb_data[2*p] = in_data_i[(2*p)*DATA_WIDTH +: DATA_WIDTH]
                              + in_data_i[(2*p+1)*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         default: comb_data[0] = full_sum;
      endcase
   end

   // Output slots that carry data in the latched mode
   always_comb begin
      active = '0;
      case (mode_q)
         MODE_BYPASS: active = '1;
         MODE_PAIR: begin
            for (int k = 0; k < N_CH; k++) begin
               active[k] = (k % 2 == 0);
            end
         end
         default: active[0] = 1'b1;
      endcase
   end

   // Join: all inputs valid and every active slot can take a new value this cycle
   always_comb begin
      slot_free = ~out_valid_q | out_ready_i;
      slot_hs   = out_valid_q & out_ready_i;
      accept    = (state_q == ST_RUN) && (&in_valid_i)
                  && ((mode_q == MODE_ACCUM) || (&(slot_free | ~active)));
      last_beat = (cnt_q == LEN_WIDTH'(1));
      done      = !clear_i && (((state_q == ST_DRAIN) && (&slot_free))
                               || ((state_q == ST_EMIT) && slot_hs[0]));
   end

   assign in_ready_o  = {N_CH{accept}};
   assign out_valid_o = out_valid_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done;

   for (genvar g = 0; g < N_CH; g++) begin : g_out
      assign out_data_o[g*DATA_WIDTH +: DATA_WIDTH] = out_data_q[g];
   end

   // Job sequencing, beat counting, accumulation and output slot registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_BYPASS;
         cnt_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= '0;
         for (int k = 0; k < N_CH; k++) out_data_q[k] <= '0;
      end else if (clear_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= '0;
         for (int k = 0; k < N_CH; k++) out_data_q[k] <= '0;
      end else begin
         // slots drain independently; a same-cycle load below overrides this
         out_valid_q <= out_valid_q & ~out_ready_i;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  mode_q  <= mode_i;
                  cnt_q   <= (len_i == '0) ? LEN_WIDTH'(1) : len_i;
                  acc_q   <= '0;
                  state_q <= ST_RUN;
                  // channels inactive in the new mode must read zero
                  for (int k = 0; k < N_CH; k++) out_data_q[k] <= '0;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  cnt_q <= cnt_q - LEN_WIDTH'(1);
                  if (mode_q == MODE_ACCUM) begin
                     if (last_beat) begin
                        out_data_q[0]  <= acc_q + full_sum;
                        out_valid_q[0] <= 1'b1;
                        state_q        <= ST_EMIT;
                     end else begin
                        acc_q <= acc_q + full_sum;
                     end
                  end else begin
                     for (int k = 0; k < N_CH; k++) begin
                        if (active[k]) begin
                           out_data_q[k]  <= comb_data[k];
                           out_valid_q[k] <= 1'b1;
                        end
                     end
                     if (last_beat) state_q <= ST_DRAIN;
                  end
               end
            end
            ST_EMIT: begin
               if (slot_hs[0]) state_q <= ST_IDLE;
            end
            ST_DRAIN: begin
               if (&slot_free) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dp_result_reducer.sv
// tb/tb_dp_result_reducer.sv - randomized self-checking bench for dp_result_reducer
module tb_dp_result_reducer;
   localparam int NC = 4;
   localparam int DW = 32;
   localparam int LW = 16;

   logic              clk;
   logic              rst_i;
   logic              clear_i;
   logic              start_i;
   logic [1:0]        mode_i;
   logic [LW-1:0]     len_i;
   logic [NC*DW-1:0]  in_data_i;
   logic [NC-1:0]     in_valid_i;
   logic [NC-1:0]     in_ready_o;
   logic [NC*DW-1:0]  out_data_o;
   logic [NC-1:0]     out_valid_o;
   logic [NC-1:0]     out_ready_i;
   logic              busy_o;
   logic              done_o;

   int n_cmp;
   int n_fail;

   logic [NC*DW-1:0] beats [$];
   logic [DW-1:0]    exp_q [NC][$];
   logic [DW-1:0]    got_q [NC][$];
   int               hs_cyc [NC][$];
   int               acc_cyc_q [$];
   int               cyc, busy_cnt, done_cnt, done_cyc, stab_viol, inact_viol, ready_uneq;
   int               stall_rdy;
   logic [1:0]       job_mode;
   logic             mon_clr;
   logic [NC-1:0]    pv, pr;
   logic             pc;
   logic [DW-1:0]    pd [NC];

   dp_result_reducer #(.N_CH(NC), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
      .mode_i(mode_i), .len_i(len_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] odata(input int k);
      return out_data_o[k*DW +: DW];
   endfunction

   function automatic bit chan_active(input logic [1:0] m, input int k);
      if (m == 2'd0) return 1'b1;
      if (m == 2'd1) return (k % 2 == 0);
      return (k == 0);
   endfunction

   // Observer: records accepts, output handshakes, done pulses and protocol violations
   always @(negedge clk) begin
      if (rst_i) begin
         cyc = 0;
      end else if (mon_clr) begin
         cyc = cyc + 1;
         busy_cnt = 0; done_cnt = 0; done_cyc = -1; stab_viol = 0; inact_viol = 0; ready_uneq = 0;
         acc_cyc_q.delete();
         for (int k = 0; k < NC; k++) begin
            got_q[k].delete();
            hs_cyc[k].delete();
         end
         pv = '0; pr = '1; pc = 1'b0;
      end else begin
         cyc = cyc + 1;
         if (busy_o) busy_cnt++;
         if (done_o) begin done_cnt++; done_cyc = cyc; end
         if (in_ready_o != '0 && in_ready_o != '1) ready_uneq++;
         if (in_ready_o[0]) acc_cyc_q.push_back(cyc);
         for (int k = 0; k < NC; k++) begin
            if (out_valid_o[k] && out_ready_i[k]) begin
               got_q[k].push_back(odata(k));
               hs_cyc[k].push_back(cyc);
            end
            if (pv[k] && !pr[k] && !pc && (!out_valid_o[k] || odata(k) !== pd[k])) stab_viol++;
            if (busy_o && !chan_active(job_mode, k) && (out_valid_o[k] || odata(k) !== '0)) inact_viol++;
            pd[k] = odata(k);
         end
         pv = out_valid_o; pr = out_ready_i; pc = clear_i;
      end
   end

   // Reference: expected output stream per channel from the beat list and mode
   task automatic build_model(input logic [1:0] m);
      logic [DW-1:0] s, acc;
      logic [NC*DW-1:0] b;
      acc = '0;
      for (int k = 0; k < NC; k++) exp_q[k].delete();
      foreach (beats[i]) begin
         b = beats[i];
         s = b[31:0] + b[63:32] + b[95:64] + b[127:96];
         case (m)
            2'd0: for (int k = 0; k < NC; k++) exp_q[k].push_back(b[k*DW +: DW]);
            2'd1: begin
               exp_q[0].push_back(b[31:0] + b[63:32]);
               exp_q[2].push_back(b[95:64] + b[127:96]);
            end
            2'd2: exp_q[0].push_back(s);
            default: acc = acc + s;
         endcase
      end
      if (m == 2'd3) exp_q[0].push_back(acc);
   endtask

   // Stimulus driver for one job; bounded by a cycle budget
   task automatic run_job(input logic [1:0] m, input int len, input bit rr, input bit rv,
                          input int v3_stall, input int r1_stall, input bit mid_start);
      int idx, t;
      bit ms;
      idx = 0; t = 0; ms = 1'b0; stall_rdy = 0;
      @(posedge clk); #1;
      job_mode = m; mon_clr = 1'b1;
      start_i = 1'b1; mode_i = m; len_i = LW'(len); in_valid_i = '0; out_ready_i = '1;
      @(posedge clk); #1;
      mon_clr = 1'b0; start_i = 1'b0;
      while (done_cnt == 0 && t < 400) begin
         if (idx < beats.size()) begin
            in_data_i  = beats[idx];
            in_valid_i = (rv && $urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         end else begin
            in_valid_i = '0;
         end
         if (t < v3_stall) in_valid_i[3] = 1'b0;
         out_ready_i = (rr && $urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         if (t < r1_stall) out_ready_i[1] = 1'b0;
         start_i = 1'b0;
         if (mid_start && idx == 1 && !ms) begin
            start_i = 1'b1; mode_i = 2'd0; len_i = LW'(9); ms = 1'b1;
         end
         @(negedge clk);
         if (t < v3_stall && in_ready_o != '0) stall_rdy++;
         if (in_ready_o[0]) idx++;
         @(posedge clk); #1;
         t++;
      end
      start_i = 1'b0; in_valid_i = '0; out_ready_i = '1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; mode_i = '0; len_i = '0;
      in_data_i = '1; in_valid_i = '1; out_ready_i = '1; mon_clr = 1'b0; job_mode = '0;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid_o !== '0) begin n_fail++; $display("FAIL reset_out_valid: got %h expected 0", out_valid_o); end
      n_cmp++; if (out_data_o !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data_o); end
      n_cmp++; if (in_ready_o !== '0) begin n_fail++; $display("FAIL reset_in_ready: got %h expected 0", in_ready_o); end
      n_cmp++; if ({busy_o, done_o} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {busy_o, done_o}); end
      in_valid_i = '0;
   endtask

   task automatic test_bypass;
      beats = '{ {32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5} };
      build_model(2'd0);
      run_job(2'd0, 2, 1'b0, 1'b0, 0, 0, 1'b0);
      for (int k = 0; k < NC; k++) begin
         n_cmp++;
         if (got_q[k].size() != exp_q[k].size()) begin
            n_fail++; $display("FAIL bypass_count ch%0d: got %0d expected %0d", k, got_q[k].size(), exp_q[k].size());
         end else begin
            for (int i = 0; i < exp_q[k].size(); i++) begin
               n_cmp++;
               if (got_q[k][i] !== exp_q[k][i]) begin n_fail++; $display("FAIL bypass_data ch%0d beat %0d: got %h expected %h", k, i, got_q[k][i], exp_q[k][i]); end
            end
         end
      end
      n_cmp++; if (got_q[3].size() > 1 && got_q[3][1] !== 32'd8) begin n_fail++; $display("FAIL bypass_ch3_beat1: got %0d expected 8", got_q[3][1]); end
      n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL bypass_done: got %0d pulses expected 1", done_cnt); end
      n_cmp++; if (busy_cnt != 3) begin n_fail++; $display("FAIL bypass_busy: got %0d cycles expected 3", busy_cnt); end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (hs_cyc[0][i] != acc_cyc_q[i] + 1) begin n_fail++; $display("FAIL bypass_latency beat %0d: out at %0d accept at %0d", i, hs_cyc[0][i], acc_cyc_q[i]); end
      end
   endtask

   task automatic test_pair_stall;
      beats = '{ {32'd40, 32'd30, 32'd20, 32'd10} };
      build_model(2'd1);
      run_job(2'd1, 1, 1'b0, 1'b0, 2, 0, 1'b0);
      n_cmp++; if (stall_rdy != 0) begin n_fail++; $display("FAIL pair_stall_ready: got %0d ready cycles expected 0", stall_rdy); end
      n_cmp++; if (got_q[0].size() != 1 || got_q[0][0] !== 32'd30) begin n_fail++; $display("FAIL pair_out0: got %0d items first %0d expected one 30", got_q[0].size(), got_q[0][0]); end
      n_cmp++; if (got_q[2].size() != 1 || got_q[2][0] !== 32'd70) begin n_fail++; $display("FAIL pair_out2: got %0d items first %0d expected one 70", got_q[2].size(), got_q[2][0]); end
      n_cmp++; if (got_q[1].size() + got_q[3].size() != 0 || inact_viol != 0) begin n_fail++; $display("FAIL pair_odd_inactive: got %0d outputs %0d violations expected 0", got_q[1].size() + got_q[3].size(), inact_viol); end
      n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL pair_done: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_full_wrap;
      beats = '{ {32'd3, 32'd2, 32'd1, 32'hFFFF_FFFF} };
      run_job(2'd2, 0, 1'b0, 1'b0, 0, 0, 1'b0);
      n_cmp++; if (got_q[0].size() != 1 || got_q[0][0] !== 32'h0000_0005) begin n_fail++; $display("FAIL full_wrap: got %0d items first %h expected one 00000005", got_q[0].size(), got_q[0][0]); end
      n_cmp++; if (done_cnt != 1 || inact_viol != 0) begin n_fail++; $display("FAIL full_done: got done %0d inactive violations %0d expected 1/0", done_cnt, inact_viol); end
   endtask

   task automatic test_accum;
      beats = '{ {4{32'd1}}, {4{32'd2}}, {4{32'd3}} };
      run_job(2'd3, 3, 1'b0, 1'b0, 0, 0, 1'b0);
      n_cmp++; if (got_q[0].size() != 1 || got_q[0][0] !== 32'd24) begin n_fail++; $display("FAIL accum_sum: got %0d items first %0d expected one 24", got_q[0].size(), got_q[0][0]); end
      n_cmp++; if (acc_cyc_q.size() != 3 || hs_cyc[0][0] != acc_cyc_q[2] + 1) begin n_fail++; $display("FAIL accum_latency: out at %0d last accept at %0d", hs_cyc[0][0], acc_cyc_q[2]); end
      n_cmp++; if (done_cnt != 1 || done_cyc != hs_cyc[0][0]) begin n_fail++; $display("FAIL accum_done: done at %0d count %0d handshake at %0d", done_cyc, done_cnt, hs_cyc[0][0]); end
   endtask

   task automatic test_drain;
      beats.delete();
      for (int i = 0; i < 2; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
      build_model(2'd0);
      run_job(2'd0, 2, 1'b0, 1'b0, 0, 5, 1'b0);
      for (int k = 0; k < NC; k++) begin
         n_cmp++;
         if (got_q[k].size() != 2 || got_q[k][0] !== exp_q[k][0] || got_q[k][1] !== exp_q[k][1]) begin
            n_fail++; $display("FAIL drain_data ch%0d: got %h %h expected %h %h", k, got_q[k][0], got_q[k][1], exp_q[k][0], exp_q[k][1]);
         end
      end
      for (int k = 0; k < NC; k++) begin
         n_cmp++;
         if (hs_cyc[k][0] != acc_cyc_q[0] + ((k == 1) ? 5 : 1)) begin n_fail++; $display("FAIL drain_timing ch%0d: handshake at %0d accept at %0d", k, hs_cyc[k][0], acc_cyc_q[0]); end
      end
      n_cmp++; if (acc_cyc_q.size() != 2 || acc_cyc_q[1] != hs_cyc[1][0]) begin n_fail++; $display("FAIL drain_blocked_accept: second accept at %0d ch1 drain at %0d", acc_cyc_q[1], hs_cyc[1][0]); end
      n_cmp++; if (stab_viol != 0) begin n_fail++; $display("FAIL drain_stable: got %0d violations expected 0", stab_viol); end
   endtask

   task automatic test_ignored_start;
      beats.delete();
      for (int i = 0; i < 3; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
      build_model(2'd3);
      run_job(2'd3, 3, 1'b0, 1'b0, 0, 0, 1'b1);
      n_cmp++; if (got_q[0].size() != 1 || got_q[0][0] !== exp_q[0][0]) begin n_fail++; $display("FAIL ignored_start_sum: got %0d items first %h expected %h", got_q[0].size(), got_q[0][0], exp_q[0][0]); end
      n_cmp++; if (done_cnt != 1 || got_q[1].size() != 0) begin n_fail++; $display("FAIL ignored_start_done: got done %0d ch1 items %0d expected 1/0", done_cnt, got_q[1].size()); end
   endtask

   task automatic test_clear;
      @(posedge clk); #1;
      job_mode = 2'd3; mon_clr = 1'b1; start_i = 1'b1; mode_i = 2'd3; len_i = LW'(3); in_valid_i = '0;
      @(posedge clk); #1;
      mon_clr = 1'b0; start_i = 1'b0; in_data_i = {4{32'd2}}; in_valid_i = '1;
      @(negedge clk);
      n_cmp++; if (in_ready_o !== 4'hF) begin n_fail++; $display("FAIL clear_first_accept: got %h expected f", in_ready_o); end
      @(posedge clk); #1;
      in_valid_i = '0; clear_i = 1'b1; start_i = 1'b1; mode_i = 2'd3; len_i = LW'(1);
      @(posedge clk); #1;
      clear_i = 1'b0; start_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy_o !== 1'b0 || out_valid_o !== '0) begin n_fail++; $display("FAIL clear_idle: got busy %b valid %h expected 0/0", busy_o, out_valid_o); end
      n_cmp++; if (done_cnt != 0) begin n_fail++; $display("FAIL clear_no_done: got %0d expected 0", done_cnt); end
      beats = '{ {4{32'd1}} };
      run_job(2'd3, 1, 1'b0, 1'b0, 0, 0, 1'b0);
      n_cmp++; if (got_q[0].size() != 1 || got_q[0][0] !== 32'd4) begin n_fail++; $display("FAIL clear_fresh_accum: got %0d items first %0d expected one 4", got_q[0].size(), got_q[0][0]); end
   endtask

   task automatic test_random;
      logic [1:0] m;
      int len, n;
      for (int j = 0; j < 25; j++) begin
         m = 2'($urandom_range(0, 3));
         len = $urandom_range(0, 5);
         n = (len == 0) ? 1 : len;
         beats.delete();
         for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
         build_model(m);
         run_job(m, len, 1'b1, 1'b1, 0, 0, 1'b0);
         for (int k = 0; k < NC; k++) begin
            n_cmp++;
            if (got_q[k].size() != exp_q[k].size()) begin
               n_fail++; $display("FAIL rand_count job %0d mode %0d ch%0d: got %0d expected %0d", j, m, k, got_q[k].size(), exp_q[k].size());
            end else begin
               for (int i = 0; i < exp_q[k].size(); i++) begin
                  n_cmp++;
                  if (got_q[k][i] !== exp_q[k][i]) begin n_fail++; $display("FAIL rand_data job %0d ch%0d beat %0d: got %h expected %h", j, k, i, got_q[k][i], exp_q[k][i]); end
               end
            end
         end
         n_cmp++;
         if (done_cnt != 1 || stab_viol != 0 || inact_viol != 0 || ready_uneq != 0) begin
            n_fail++; $display("FAIL rand_protocol job %0d: done %0d stable %0d inactive %0d ready %0d expected 1/0/0/0", j, done_cnt, stab_viol, inact_viol, ready_uneq);
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      test_reset();
      test_bypass();
      test_pair_stall();
      test_full_wrap();
      test_accum();
      test_drain();
      test_ignored_start();
      test_clear();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
